// File: rtl/axi_lite_regfile_ctrl.sv
// AXI4-Lite slave that serialises host reads/writes onto the 16x32 register file, one transaction in flight.
// Define REGCTRL_WSTRB_EN to honour byte strobes through a read-modify-write cycle (WR_RMW state).
module axi_lite_regfile_ctrl #(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_SIZE       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [ADDR_WIDTH-1:0]     rf_write_addr,
  output logic [DATA_WIDTH-1:0]     rf_write_data,
  output logic                      rf_write_en,
  output logic [ADDR_WIDTH-1:0]     rf_read_addr,
  input  logic [DATA_WIDTH-1:0]     rf_read_data
);

  localparam int                      STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH:0] OOR_BASE    = (AXI_ADDR_WIDTH + 1)'(MEM_SIZE * 4);
  localparam logic [1:0]              RESP_OKAY   = 2'b00;
  localparam logic [1:0]              RESP_SLVERR = 2'b10;
  localparam logic                    LG_WRITE    = 1'b0;
  localparam logic                    LG_READ     = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
`ifdef REGCTRL_WSTRB_EN
    WR_RMW  = 3'd1,
`endif
    WR_EXEC = 3'd2,
    WR_RESP = 3'd3,
    RD_EXEC = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    oor_q, oor_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef REGCTRL_WSTRB_EN
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
`else
  logic                    unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb;
`endif

  logic wr_req, rd_req, grant_wr, grant_rd;

  // On a simultaneous request the type that did not win last time goes first.
  assign wr_req   = s_axi_awvalid & s_axi_wvalid;
  assign rd_req   = s_axi_arvalid;
  assign grant_wr = wr_req & (~rd_req | (last_q == LG_READ));
  assign grant_rd = rd_req & ~grant_wr;

  assign s_axi_awready = (state_q == IDLE) & grant_wr & ~reset;
  assign s_axi_wready  = (state_q == IDLE) & grant_wr & ~reset;
  assign s_axi_arready = (state_q == IDLE) & grant_rd & ~reset;

  assign s_axi_bvalid  = (state_q == WR_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (state_q == RD_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign rf_write_en   = (state_q == WR_EXEC) & ~oor_q & ~reset;
  assign rf_write_addr = idx_q;
  assign rf_write_data = wdata_q;
  assign rf_read_addr  = idx_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
`ifdef REGCTRL_WSTRB_EN
    wstrb_d = wstrb_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          idx_d   = s_axi_awaddr[ADDR_WIDTH+1:2];
          wdata_d = s_axi_wdata;
          oor_d   = ({1'b0, s_axi_awaddr} >= OOR_BASE);
          last_d  = LG_WRITE;
`ifdef REGCTRL_WSTRB_EN
          wstrb_d = s_axi_wstrb;
          state_d = WR_RMW;
`else
          state_d = WR_EXEC;
`endif
        end else if (grant_rd) begin
          idx_d   = s_axi_araddr[ADDR_WIDTH+1:2];
          oor_d   = ({1'b0, s_axi_araddr} >= OOR_BASE);
          last_d  = LG_READ;
          state_d = RD_EXEC;
        end
      end
`ifdef REGCTRL_WSTRB_EN
      WR_RMW: begin
        // Unstrobed bytes keep the value currently held in the register.
        for (int i = 0; i < STRB_WIDTH; i++) begin
          if (!wstrb_q[i]) wdata_d[8*i +: 8] = rf_read_data[8*i +: 8];
        end
        state_d = WR_EXEC;
      end
`endif
      WR_EXEC: begin
        bresp_d = oor_q ? RESP_SLVERR : RESP_OKAY;
        state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_axi_bready) state_d = IDLE;
      end
      RD_EXEC: begin
        rdata_d = oor_q ? '0 : rf_read_data;
        rresp_d = oor_q ? RESP_SLVERR : RESP_OKAY;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        if (s_axi_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LG_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
`ifdef REGCTRL_WSTRB_EN
      wstrb_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
`ifdef REGCTRL_WSTRB_EN
      wstrb_q <= wstrb_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_ctrl.sv
// Directed bench for axi_lite_regfile_ctrl with a behavioural 16x32 register file attached.
module tb_axi_lite_regfile_ctrl;

`ifdef REGCTRL_WSTRB_EN
  localparam int WLAT = 3;
`else
  localparam int WLAT = 2;
`endif
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [3:0]  rf_write_addr, rf_read_addr;
  logic [31:0] rf_write_data, rf_read_data;
  logic        rf_write_en;

  axi_lite_regfile_ctrl dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data)
  );

  logic [31:0] rf_mem [16];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (rf_write_en) begin
      rf_mem[rf_write_addr] <= rf_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign rf_read_data = rf_mem[rf_read_addr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_write(input string nm, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
    int n, lat, en_at, wr0;
    logic [3:0] en_addr;
    @(negedge clk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    #1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({nm, " aw/w handshake"}, 32'(s_axi_awready & s_axi_wready), 32'd1);
    wr0 = wr_cnt;
    lat = 0; en_at = 0; en_addr = '0;
    do begin
      @(negedge clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      #1; lat++;
      if (rf_write_en) begin
        en_at = lat; en_addr = rf_write_addr;
      end
    end while (!s_axi_bvalid && lat < 20);
    check({nm, " bvalid latency"}, 32'(lat), 32'(WLAT));
    check({nm, " write pulse cycle"}, 32'(en_at), (er == OK) ? 32'(WLAT - 1) : 32'd0);
    if (er == OK) begin
      logic [7:0] a_l;
      a_l = a;
      check({nm, " write index"}, 32'(en_addr), 32'(a_l[5:2]));
    end
    check({nm, " bresp"}, 32'(s_axi_bresp), 32'(er));
    @(negedge clk); #1;
    check({nm, " bvalid cleared"}, 32'(s_axi_bvalid), 32'd0);
    check({nm, " write pulse count"}, 32'(wr_cnt - wr0), (er == OK) ? 32'd1 : 32'd0);
  endtask

  task automatic do_read(input string nm, input logic [7:0] a, input logic [31:0] ed,
                         input logic [1:0] er);
    int n, lat;
    @(negedge clk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({nm, " ar handshake"}, 32'(s_axi_arready), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      s_axi_arvalid = 1'b0;
      #1; lat++;
    end while (!s_axi_rvalid && lat < 20);
    check({nm, " rvalid latency"}, 32'(lat), 32'd2);
    check({nm, " rdata"}, s_axi_rdata, ed);
    check({nm, " rresp"}, 32'(s_axi_rresp), 32'(er));
    @(negedge clk); #1;
    check({nm, " rvalid cleared"}, 32'(s_axi_rvalid), 32'd0);
  endtask

  typedef struct packed {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  initial begin
    int n;
    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;

    vecs[0]  = '{1'b1, 8'h00, 32'h0000_0280, 4'hF, OK,  32'h0};
    vecs[1]  = '{1'b1, 8'h04, 32'h0000_01E0, 4'hF, OK,  32'h0};
    vecs[2]  = '{1'b0, 8'h04, 32'h0,         4'h0, OK,  32'h0000_01E0};
    vecs[3]  = '{1'b0, 8'h00, 32'h0,         4'h0, OK,  32'h0000_0280};
    vecs[4]  = '{1'b1, 8'h3D, 32'hDEAD_BEEF, 4'hF, OK,  32'h0};
    vecs[5]  = '{1'b0, 8'h3C, 32'h0,         4'h0, OK,  32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 8'h3F, 32'h0,         4'h0, OK,  32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 8'h40, 32'h1234_5678, 4'hF, ERR, 32'h0};
    vecs[8]  = '{1'b0, 8'h40, 32'h0,         4'h0, ERR, 32'h0};
    vecs[9]  = '{1'b0, 8'hFC, 32'h0,         4'h0, ERR, 32'h0};
    vecs[10] = '{1'b0, 8'h00, 32'h0,         4'h0, OK,  32'h0000_0280};
    vecs[11] = '{1'b1, 8'h08, 32'hA5A5_5A5A, 4'hF, OK,  32'h0};
    vecs[12] = '{1'b0, 8'h0A, 32'h0,         4'h0, OK,  32'hA5A5_5A5A};

    repeat (3) @(negedge clk);
    #1;
    check("reset awready", 32'(s_axi_awready), 32'd0);
    check("reset arready", 32'(s_axi_arready), 32'd0);
    check("reset bvalid", 32'(s_axi_bvalid), 32'd0);
    check("reset rvalid", 32'(s_axi_rvalid), 32'd0);
    check("reset bresp", 32'(s_axi_bresp), 32'd0);
    check("reset rresp", 32'(s_axi_rresp), 32'd0);
    check("reset rdata", s_axi_rdata, 32'd0);
    check("reset rf_write_en", 32'(rf_write_en), 32'd0);
    check("reset rf_write_addr", 32'(rf_write_addr), 32'd0);
    check("reset rf_read_addr", 32'(rf_read_addr), 32'd0);
    check("reset rf_write_data", rf_write_data, 32'd0);
    reset = 1'b0;

    // Back-to-back conflicts right after reset: write first, then read.
    @(negedge clk);
    s_axi_awaddr = 8'h10; s_axi_wdata = 32'h0000_0077; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 8'h10; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    #1;
    check("conflict1 awready", 32'(s_axi_awready), 32'd1);
    check("conflict1 arready", 32'(s_axi_arready), 32'd0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(s_axi_awready || s_axi_arready) && n < 20);
    check("conflict2 gap", 32'(n), 32'(WLAT + 1));
    check("conflict2 arready", 32'(s_axi_arready), 32'd1);
    check("conflict2 awready", 32'(s_axi_awready), 32'd0);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    #1;
    n = 1;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("conflict2 rvalid latency", 32'(n), 32'd2);
    check("conflict2 rdata", s_axi_rdata, 32'h0000_0077);
    @(negedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_wr)
        do_write($sformatf("vec%0d wr", i), vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].resp);
      else
        do_read($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].rdata, vecs[i].resp);
    end

    // Response backpressure: bvalid must hold and no read may be accepted meanwhile.
    @(negedge clk);
    s_axi_awaddr = 8'h0C; s_axi_wdata = 32'h0000_0055; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    #1;
    check("bp awready", 32'(s_axi_awready), 32'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 8'h0C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    #1;
    n = 1;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("bp bvalid", 32'(s_axi_bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp hold%0d bvalid", i), 32'(s_axi_bvalid), 32'd1);
      check($sformatf("bp hold%0d bresp", i), 32'(s_axi_bresp), 32'd0);
      check($sformatf("bp hold%0d arready", i), 32'(s_axi_arready), 32'd0);
    end
    s_axi_bready = 1'b1;
    @(negedge clk); #1;
    check("bp release bvalid", 32'(s_axi_bvalid), 32'd0);
    check("bp release arready", 32'(s_axi_arready), 32'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    #1;
    n = 1;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("bp read latency", 32'(n), 32'd2);
    check("bp read rdata", s_axi_rdata, 32'h0000_0055);
    @(negedge clk); #1;

    // Reset while the write response is pending.
    s_axi_awaddr = 8'h14; s_axi_wdata = 32'h0000_0099; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    #1;
    check("rst awready", 32'(s_axi_awready), 32'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    #1;
    n = 1;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("rst bvalid before", 32'(s_axi_bvalid), 32'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("rst bvalid after", 32'(s_axi_bvalid), 32'd0);
    s_axi_bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("rst quiet%0d bvalid", i), 32'(s_axi_bvalid), 32'd0);
      check($sformatf("rst quiet%0d rf_write_en", i), 32'(rf_write_en), 32'd0);
    end
    // last_grant must be back at READ, so a conflict favours the write again.
    s_axi_awaddr = 8'h1C; s_axi_wdata = 32'h0000_0033; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 8'h1C; s_axi_arvalid = 1'b1;
    #1;
    check("rst conflict awready", 32'(s_axi_awready), 32'd1);
    check("rst conflict arready", 32'(s_axi_arready), 32'd0);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    #1;
    n = 1;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("rst conflict bvalid", 32'(s_axi_bvalid), 32'd1);
    @(negedge clk); #1;
    do_read("rst write kept", 8'h14, 32'h0000_0099, OK);

`ifdef REGCTRL_WSTRB_EN
    do_write("strb base", 8'h18, 32'hAABB_CCDD, 4'hF, OK);
    do_write("strb byte0", 8'h18, 32'h0000_0011, 4'b0001, OK);
    do_read("strb merged", 8'h18, 32'hAABB_CC11, OK);
    do_write("strb none", 8'h18, 32'hFFFF_FFFF, 4'b0000, OK);
    do_read("strb unchanged", 8'h18, 32'hAABB_CC11, OK);
`else
    do_write("strb base", 8'h18, 32'hAABB_CCDD, 4'hF, OK);
    do_write("strb ignored", 8'h18, 32'h0000_0011, 4'b0001, OK);
    do_read("strb full word", 8'h18, 32'h0000_0011, OK);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
